// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared constants and types for the background video path
package video_pkg;

    localparam int ROW_WORDS = 800;
    localparam int PIXEL_W   = 16;
    localparam int LINE_W    = 10;
    localparam int ADDR_W    = 20;

    localparam int RED_LSB   = 0;
    localparam int RED_MSB   = 3;
    localparam int GREEN_LSB = 4;
    localparam int GREEN_MSB = 7;
    localparam int BLUE_LSB  = 8;
    localparam int BLUE_MSB  = 11;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/row_addr_mult.sv
// rtl/row_addr_mult.sv - combinational line x 800 row base address
module row_addr_mult
    import video_pkg::*;
(
    input  line_t line,
    output addr_t addr
);

    addr_t line_ext;

    // 800 = 512 + 256 + 32
    assign line_ext = addr_t'(line);
    assign addr     = (line_ext << 9) + (line_ext << 8) + (line_ext << 5);

endmodule

// File: rtl/scanline_fifo.sv
// rtl/scanline_fifo.sv - row base address and pixel FIFO between SRAM fetch and colour mux
module scanline_fifo
    import video_pkg::LINE_W, video_pkg::ADDR_W;
#(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 1024,
    parameter int ROW_WORDS = 800
) (
    input  logic                       clk100,
    input  logic                       rst_n,
    input  logic [LINE_W-1:0]          v_pos,
    output logic [ADDR_W-1:0]          addr_offset,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_req,
    output logic                       full,
    input  logic                       rd_req,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     used_words
);

    localparam int AW = $clog2(DEPTH);

    if (ROW_WORDS != 800 || DEPTH < 800 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("scanline_fifo: unsupported DEPTH/ROW_WORDS");
    end

    row_addr_mult u_row_addr_mult (
        .line (v_pos),
        .addr (addr_offset)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              wr_ok;
    logic              rd_ok;

    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign used_words = count;

    // Requests arriving in a reset cycle are discarded along with the contents.
    assign wr_ok = rst_n && wr_req && !full;
    assign rd_ok = rst_n && rd_req && !empty;

    always_ff @(posedge clk100) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_scanline_fifo.sv
// tb/tb_scanline_fifo.sv - directed self-checking bench for scanline_fifo
module tb_scanline_fifo;

    logic        clk100 = 1'b0;
    logic        rst_n;
    logic [9:0]  v_pos;
    logic [19:0] addr_offset;
    logic [15:0] wr_data;
    logic        wr_req;
    logic        full;
    logic        rd_req;
    logic [15:0] rd_data;
    logic        empty;
    logic [10:0] used_words;

    int n_cmp = 0;
    int n_bad = 0;

    scanline_fifo dut (
        .clk100      (clk100),
        .rst_n       (rst_n),
        .v_pos       (v_pos),
        .addr_offset (addr_offset),
        .wr_data     (wr_data),
        .wr_req      (wr_req),
        .full        (full),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .empty       (empty),
        .used_words  (used_words)
    );

    always #5 clk100 = ~clk100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk100);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        rst_n   = 1'b0;
        v_pos   = '0;
        wr_data = '0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;

        // multiplier corner values and full sweep
        v_pos = 10'd0;    #1 check("mul_0",    32'(addr_offset), 32'd0);
        v_pos = 10'd1;    #1 check("mul_1",    32'(addr_offset), 32'd800);
        v_pos = 10'd479;  #1 check("mul_479",  32'(addr_offset), 32'd383200);
        v_pos = 10'd599;  #1 check("mul_599",  32'(addr_offset), 32'd479200);
        v_pos = 10'd1023; #1 check("mul_1023", 32'(addr_offset), 32'd818400);
        for (int v = 0; v < 1024; v++) begin
            v_pos = 10'(v);
            #1 check("mul_sweep", 32'(addr_offset), 32'(v * 800));
        end

        // reset state, with requests presented during reset
        wr_req = 1'b1; rd_req = 1'b1; wr_data = 16'h0055;
        step();
        step();
        wr_req = 1'b0; rd_req = 1'b0;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_used",  32'(used_words), 32'd0);
        check("rst_rdata", 32'(rd_data), 32'd0);
        rst_n = 1'b1;

        // reset mid-operation discards stored words
        for (int i = 0; i < 5; i++) begin
            wr_req = 1'b1; wr_data = 16'(16'h00A0 + i);
            step();
        end
        wr_req = 1'b0;
        check("fill5_used", 32'(used_words), 32'd5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst2_empty", 32'(empty), 32'd1);
        check("rst2_full",  32'(full),  32'd0);
        check("rst2_used",  32'(used_words), 32'd0);
        check("rst2_rdata", 32'(rd_data), 32'd0);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check("rst2_rd_hold", 32'(rd_data), 32'd0);
        check("rst2_rd_used", 32'(used_words), 32'd0);

        // one line transfer of 800 words
        for (int i = 0; i < 800; i++) begin
            wr_req = 1'b1; wr_data = 16'(i);
            step();
        end
        wr_req = 1'b0;
        check("line_used",  32'(used_words), 32'd800);
        check("line_empty", 32'(empty), 32'd0);
        got = 0;
        for (int c = 0; c < 1000 && got < 800; c++) begin
            rd_req = !empty;
            step();
            if (rd_req) begin
                check("line_data", 32'(rd_data), 32'(got));
                got++;
            end
        end
        rd_req = 1'b0;
        check("line_count", 32'(got), 32'd800);
        check("line_empty_end", 32'(empty), 32'd1);

        // fill past capacity: the last three writes are dropped
        for (int i = 0; i < 1027; i++) begin
            wr_req = 1'b1; wr_data = 16'(i) ^ 16'h5A5A;
            step();
            if (i == 1023) begin
                check("full_at_1024", 32'(full), 32'd1);
                check("used_at_1024", 32'(used_words), 32'd1024);
            end
        end
        // write while full is dropped even with a simultaneous read
        wr_req = 1'b1; wr_data = 16'hFFFF; rd_req = 1'b1;
        step();
        wr_req = 1'b0; rd_req = 1'b0;
        check("full_rw_used", 32'(used_words), 32'd1023);
        check("full_rw_data", 32'(rd_data), 32'h5A5A);
        check("full_rw_flag", 32'(full), 32'd0);
        got = 1;
        for (int c = 0; c < 1200 && got < 1024; c++) begin
            rd_req = !empty;
            step();
            if (rd_req) begin
                check("full_data", 32'(rd_data), 32'(16'(got) ^ 16'h5A5A));
                got++;
            end
        end
        rd_req = 1'b0;
        check("full_count", 32'(got), 32'd1024);
        check("full_empty_end", 32'(empty), 32'd1);

        // half full, then steady simultaneous read/write across the pointer wrap
        for (int i = 0; i < 512; i++) begin
            wr_req = 1'b1; wr_data = 16'(16'h2000 + i);
            step();
        end
        check("half_used", 32'(used_words), 32'd512);
        for (int k = 0; k < 300; k++) begin
            wr_req = 1'b1; rd_req = 1'b1; wr_data = 16'(16'h2000 + 512 + k);
            step();
            check("rw_used", 32'(used_words), 32'd512);
            check("rw_data", 32'(rd_data), 32'(16'h2000 + k));
        end
        wr_req = 1'b0;
        got = 300;
        for (int c = 0; c < 700 && got < 812; c++) begin
            rd_req = !empty;
            step();
            if (rd_req) begin
                check("drain_data", 32'(rd_data), 32'(16'h2000 + got));
                got++;
            end
        end
        rd_req = 1'b0;
        check("drain_count", 32'(got), 32'd812);

        // underflow is ignored, single word round trip
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check("under_hold", 32'(rd_data), 32'h232B);
        check("under_used", 32'(used_words), 32'd0);
        check("under_empty", 32'(empty), 32'd1);
        wr_req = 1'b1; wr_data = 16'hBEEF;
        step();
        wr_req = 1'b0;
        check("one_empty", 32'(empty), 32'd0);
        check("one_used", 32'(used_words), 32'd1);
        check("one_nodata", 32'(rd_data), 32'h232B);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check("one_data", 32'(rd_data), 32'hBEEF);
        check("one_empty_end", 32'(empty), 32'd1);
        step();
        check("idle_hold", 32'(rd_data), 32'hBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
